// File: rtl/adrv9001_tdd_seq.sv
// TDD enable sequencer for one ADRV9001 RX/TX channel pair: a programmable frame
// counter decoded into RX/TX pin enables and delayed SSI datapath enables.
module adrv9001_tdd_seq #(
  parameter int unsigned CNT_WIDTH = 24,
  parameter int unsigned FRM_WIDTH = 16
) (
  input  logic                 s_axi_aclk,
  input  logic                 s_axi_aresetn,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] frame_len,
  input  logic [FRM_WIDTH-1:0] num_frames,
  input  logic [CNT_WIDTH-1:0] rx_on,
  input  logic [CNT_WIDTH-1:0] rx_off,
  input  logic [CNT_WIDTH-1:0] tx_on,
  input  logic [CNT_WIDTH-1:0] tx_off,
  input  logic [7:0]           ssi_dly,
  output logic                 rx_en,
  output logic                 tx_en,
  output logic                 rx_ssi_en,
  output logic                 tx_ssi_en,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err,
  output logic [FRM_WIDTH-1:0] frame_cnt
);

  localparam int unsigned XW = CNT_WIDTH + 1;
  localparam int unsigned DW = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]          dcnt_q, dcnt_d;
  logic [FRM_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
  logic                   stop_pend_q, stop_pend_d;
  logic [CNT_WIDTH-1:0]   frame_len_q, frame_len_d;
  logic [FRM_WIDTH-1:0]   num_frames_q, num_frames_d;
  logic [CNT_WIDTH-1:0]   rx_on_q, rx_on_d, rx_off_q, rx_off_d;
  logic [CNT_WIDTH-1:0]   tx_on_q, tx_on_d, tx_off_q, tx_off_d;
  logic [DW-1:0]          ssi_dly_q, ssi_dly_d;
  logic                   rx_en_q, rx_en_d, tx_en_q, tx_en_d;
  logic                   rx_ssi_en_q, rx_ssi_en_d, tx_ssi_en_q, tx_ssi_en_d;
  logic                   busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;

  logic                   wrap_c, last_frame_c, drain_done_c, load_c, run_dec_c;
  logic [FRM_WIDTH-1:0]   frame_inc_c;
  logic [XW-1:0]          flen_p1_c;
  logic                   overlap_c, cfg_bad_c;
  logic                   rx_win_c, rx_ssi_win_c, tx_win_c, tx_ssi_win_c;

  assign wrap_c       = (state_q == S_RUN) && (cnt_q == frame_len_q);
  assign frame_inc_c  = frame_cnt_q + FRM_WIDTH'(1);
  assign last_frame_c = (num_frames_q != '0) && (frame_inc_c == num_frames_q);
  assign drain_done_c = (dcnt_q == ssi_dly_q);

  // Config sanity is judged on the live inputs, i.e. the values about to be latched.
  assign flen_p1_c = {1'b0, frame_len} + XW'(1);
  assign overlap_c = (rx_on < rx_off) && (tx_on < tx_off) && (rx_on < tx_off) && (tx_on < rx_off);
  assign cfg_bad_c = ({1'b0, rx_off} > flen_p1_c) || ({1'b0, tx_off} > flen_p1_c) ||
                     overlap_c || (frame_len == '0);

  // SSI start uses a widened add so on+ssi_dly cannot wrap into the window.
  assign rx_win_c     = (cnt_q >= rx_on_q) && (cnt_q < rx_off_q);
  assign tx_win_c     = (cnt_q >= tx_on_q) && (cnt_q < tx_off_q);
  assign rx_ssi_win_c = ({1'b0, cnt_q} >= ({1'b0, rx_on_q} + XW'(ssi_dly_q))) && (cnt_q < rx_off_q);
  assign tx_ssi_win_c = ({1'b0, cnt_q} >= ({1'b0, tx_on_q} + XW'(ssi_dly_q))) && (cnt_q < tx_off_q);

  assign load_c    = ((state_q == S_IDLE) && start) || (wrap_c && !abort);
  assign run_dec_c = (state_q == S_RUN) && !abort;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) state_q <= S_IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN: begin
        if (abort)                                           state_d = S_IDLE;
        else if (wrap_c && (stop_pend_q || stop || last_frame_c)) state_d = S_DRAIN;
      end
      S_DRAIN: if (abort || drain_done_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    dcnt_d       = dcnt_q;
    frame_cnt_d  = frame_cnt_q;
    stop_pend_d  = stop_pend_q;
    frame_len_d  = frame_len_q;
    num_frames_d = num_frames_q;
    rx_on_d      = rx_on_q;
    rx_off_d     = rx_off_q;
    tx_on_d      = tx_on_q;
    tx_off_d     = tx_off_q;
    ssi_dly_d    = ssi_dly_q;
    cfg_err_d    = cfg_err_q;
    done_d       = 1'b0;
    busy_d       = (state_d != S_IDLE);
    // TX owns the antenna during any overlap.
    tx_en_d      = run_dec_c && tx_win_c;
    tx_ssi_en_d  = run_dec_c && tx_ssi_win_c;
    rx_en_d      = run_dec_c && rx_win_c && !tx_win_c;
    rx_ssi_en_d  = run_dec_c && rx_ssi_win_c && !tx_win_c;

    if (load_c) begin
      frame_len_d  = frame_len;
      num_frames_d = num_frames;
      rx_on_d      = rx_on;
      rx_off_d     = rx_off;
      tx_on_d      = tx_on;
      tx_off_d     = tx_off;
      ssi_dly_d    = ssi_dly;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d       = '0;
          frame_cnt_d = '0;
          stop_pend_d = 1'b0;
          cfg_err_d   = cfg_bad_c;
        end
      end
      S_RUN: begin
        if (abort) begin
          done_d      = 1'b1;
          stop_pend_d = 1'b0;
        end else begin
          if (stop) stop_pend_d = 1'b1;
          if (wrap_c) begin
            cnt_d       = '0;
            frame_cnt_d = frame_inc_c;
            cfg_err_d   = cfg_err_q || cfg_bad_c;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
          if (state_d == S_DRAIN) begin
            dcnt_d      = '0;
            stop_pend_d = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        if (abort || drain_done_c) done_d = 1'b1;
        else                       dcnt_d = dcnt_q + DW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      cnt_q        <= '0;
      dcnt_q       <= '0;
      frame_cnt_q  <= '0;
      stop_pend_q  <= 1'b0;
      frame_len_q  <= '0;
      num_frames_q <= '0;
      rx_on_q      <= '0;
      rx_off_q     <= '0;
      tx_on_q      <= '0;
      tx_off_q     <= '0;
      ssi_dly_q    <= '0;
      rx_en_q      <= 1'b0;
      tx_en_q      <= 1'b0;
      rx_ssi_en_q  <= 1'b0;
      tx_ssi_en_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      dcnt_q       <= dcnt_d;
      frame_cnt_q  <= frame_cnt_d;
      stop_pend_q  <= stop_pend_d;
      frame_len_q  <= frame_len_d;
      num_frames_q <= num_frames_d;
      rx_on_q      <= rx_on_d;
      rx_off_q     <= rx_off_d;
      tx_on_q      <= tx_on_d;
      tx_off_q     <= tx_off_d;
      ssi_dly_q    <= ssi_dly_d;
      rx_en_q      <= rx_en_d;
      tx_en_q      <= tx_en_d;
      rx_ssi_en_q  <= rx_ssi_en_d;
      tx_ssi_en_q  <= tx_ssi_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign rx_en     = rx_en_q;
  assign tx_en     = tx_en_q;
  assign rx_ssi_en = rx_ssi_en_q;
  assign tx_ssi_en = tx_ssi_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/adrv9001_tdd_seq.md
Name: adrv9001_tdd_seq

Overview:
- Time-division-duplex enable sequencer for one ADRV9001 RX/TX channel pair; one instance per pair.
- Runs a programmable frame counter and, from it, generates the RX and TX pin enables plus the SSI datapath enables.
- The existing RX/TX datapath is held in reset whenever its enable or its SSI enable is low.
- Sits between the register block and the top-level enable outputs, replacing static register-driven enables when TDD mode is selected.

Parameters:
- CNT_WIDTH, 24, width of the frame counter and of all timing fields.
- FRM_WIDTH, 16, width of the frame-count field.

Ports:
- s_axi_aclk  in  1  sole clock (register-domain clock).
- s_axi_aresetn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begin sequencing (ignored unless IDLE).
- stop  in  1  single-cycle pulse; finish the current frame, then go IDLE.
- abort  in  1  single-cycle pulse; drop all enables next cycle, go IDLE.
- frame_len  in  CNT_WIDTH  frame period minus 1, in clocks.
- num_frames  in  FRM_WIDTH  frames to run; 0 = continuous.
- rx_on, rx_off  in  CNT_WIDTH  RX window start/end counts.
- tx_on, tx_off  in  CNT_WIDTH  TX window start/end counts.
- ssi_dly  in  8  clocks from pin enable to SSI enable.
- rx_en  out  1  RX pin enable.
- tx_en  out  1  TX pin enable.
- rx_ssi_en  out  1  RX datapath enable.
- tx_ssi_en  out  1  TX datapath enable.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse on return to IDLE (normal stop, stop pulse, or abort).
- cfg_err  out  1  sticky; set when the latched config is invalid; cleared by start.
- frame_cnt  out  FRM_WIDTH  completed frames since start.

Behaviour:
- Reset values: all outputs 0; state IDLE; counter 0.
- States:
  - IDLE: start -> latch all config into shadow regs, counter=0, frame_cnt=0, clear cfg_err -> RUN.
  - RUN: counter increments each clock; at counter==frame_len it wraps to 0 and frame_cnt increments. Shadow regs reload from the inputs on every wrap, so mid-frame input changes take effect only at the next frame boundary.
  - Leave RUN -> DRAIN when num_frames!=0 and the wrap sets frame_cnt==num_frames, or when stop is seen.
  - DRAIN: all enables forced 0 for ssi_dly+1 clocks, then done pulse -> IDLE.
  - abort in any non-IDLE state -> enables 0 on the next clock, done pulse on the next clock, IDLE, no DRAIN.
- Stop timing: a stop pulse in RUN is registered; the transition to DRAIN happens at the next wrap. stop or abort in IDLE is ignored.
- Window decode (registered, 1-clock latency from counter to output):
  - X_en=1 when on<=counter<off; empty when on>=off.
  - X_ssi_en=1 when on+ssi_dly<=counter<off (CNT_WIDTH+1-bit compare, no wrap).
  - X_ssi_en falls in the same cycle as X_en.
- Half-duplex priority: if the RX and TX windows overlap, TX wins and RX is masked during the overlap, so rx_en and tx_en are never both 1.
- cfg_err is set at latch time if any of the following holds; sequencing continues with the masking rules:
  - rx_off>frame_len+1 or tx_off>frame_len+1 (offending window clipped at frame_len);
  - the RX and TX windows overlap;
  - frame_len<1.
- Simultaneous events: abort beats stop beats num_frames completion. start is ignored while busy.
- Reset asserted mid-frame: all outputs 0 asynchronously; no done pulse.

Test Plan:
- Basic frame: frame_len=99, rx 10..40, tx 50..90, ssi_dly=4, num_frames=2.
  -> rx_en high for counts 10..39 (observed 1 clock later); rx_ssi_en high 14..39; tx_en high 50..89; tx_ssi_en high 54..89.
  -> Two frames run; frame_cnt=2; done pulses 5 clocks after the last wrap; cfg_err=0.
- Overlap: rx 10..60, tx 50..90.
  -> cfg_err=1; rx_en low at counts 50..59 while tx_en is high; rx_en and tx_en never both 1 across the entire frame.
- Stop and shadow reload, num_frames=0:
  -> stop pulsed at count 30 of frame 3 -> enables continue to the frame end; DRAIN; done; frame_cnt=3.
  -> tx_on changed 20->60 mid-frame -> old value holds until the wrap.
- Abort at count 55 during the TX window -> tx_en and tx_ssi_en 0 on the next clock; done the same clock; busy 0.
- Async reset during RUN -> all outputs 0 immediately; after release, start restarts with counter=0 and frame_cnt=0.
- Edge windows:
  -> rx_on=rx_off=20 -> rx_en never asserts.
  -> ssi_dly=255 with a 30-count window -> rx_ssi_en never asserts.
  -> rx_off=frame_len+1 -> rx_en stays high through the last count of the frame and cfg_err stays 0.
